gb_timer: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 40 ++++
 rtl/timer_tick_detect.sv | 59 +++++
 rtl/gb_timer.sv | 153 +++++++++++++++
 tb/tb_gb_timer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions for memory-mapped responders.
// Holds the timer register offsets (DIV/TIMA/TMA/TAC relative to the timer base address),
// the TAC clock-select and timer FSM state enums, and the TAC tap helper function.
package cpu_bus_pkg;

  // Timer register offsets from the timer base address.
  localparam logic [1:0] TIMER_OFS_DIV  = 2'd0;
  localparam logic [1:0] TIMER_OFS_TIMA = 2'd1;
  localparam logic [1:0] TIMER_OFS_TMA  = 2'd2;
  localparam logic [1:0] TIMER_OFS_TAC  = 2'd3;

  // TAC[1:0] input clock select, named by the resulting TIMA rate in Hz.
  typedef enum logic [1:0] {
    TacClk4096   = 2'b00,
    TacClk262144 = 2'b01,
    TacClk65536  = 2'b10,
    TacClk16384  = 2'b11
  } tac_clk_sel_e;

  typedef enum logic [1:0] {
    TimerRun    = 2'd0,
    TimerOvf    = 2'd1,
    TimerReload = 2'd2
  } timer_state_e;

  // Gated tick signal: the system-counter bit picked by TAC[1:0], ANDed with the enable TAC[2].
  function automatic logic tac_tick_sig(logic [2:0] tac, logic [15:0] cnt);
    logic tap;
    tap = 1'b0;
    case (tac_clk_sel_e'(tac[1:0]))
      TacClk4096:   tap = cnt[9];
      TacClk262144: tap = cnt[3];
      TacClk65536:  tap = cnt[5];
      TacClk16384:  tap = cnt[7];
      default:      tap = 1'b0;
    endcase
    return tac[2] & tap;
  endfunction

endpackage

// File: rtl/timer_tick_detect.sv
// TIMA tick generator: selects the system-counter tap named by TAC, gates it with the TAC enable
// and emits a one-clk tick on each falling edge of the gated signal.
// Configuration macro: TIMER_DIV_GLITCH_EN
//   defined   - the history flop always holds last clk's tick_sig, so DIV/TAC writes that pull
//               tick_sig low produce a tick just like the free-running counter does.
//   undefined - DIV/TAC writes resync the history to the post-write tick_sig, so only the
//               free-running counter can produce ticks.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   sys_cnt       current free-running system counter
//   tac           current TAC value
//   div_wr        DIV write commits at this edge
//   tac_wr        TAC write commits at this edge
//   tac_wdata     TAC value being written
//   tick          one-clk TIMA increment request
module timer_tick_detect
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sys_cnt,
  input  logic [2:0]  tac,
  input  logic        div_wr,
  input  logic        tac_wr,
  input  logic [2:0]  tac_wdata,
  output logic        tick
);

  logic tick_sig;
  logic hist_q, hist_d;

  assign tick_sig = tac_tick_sig(tac, sys_cnt);
  assign tick     = hist_q & ~tick_sig;

`ifdef TIMER_DIV_GLITCH_EN
  logic unused_wr;
  assign unused_wr = ^{div_wr, tac_wr, tac_wdata};
  assign hist_d    = tick_sig;
`else
  always_comb begin
    hist_d = tick_sig;
    if (div_wr) begin
      // Counter restarts at 0, where every tap bit is low.
      hist_d = 1'b0;
    end else if (tac_wr) begin
      hist_d = tac_tick_sig(tac_wdata, sys_cnt);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/gb_timer.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer responding on the CPU system bus.
// Configuration macro: TIMER_DIV_GLITCH_EN (see timer_tick_detect).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   t_cycle        CPU T-cycle phase; writes commit when it is 3
//   mem_addr       CPU bus address
//   mem_enable     CPU bus access enable
//   mem_write      CPU bus write enable
//   mem_data_in    write data
//   mem_data_out   combinational read data, 8'hFF when not selected
//   mem_selected   access hits BASE_ADDR..BASE_ADDR+3
//   irq_timer      one-clk timer interrupt request
module gb_timer
  import cpu_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_selected,
  output logic        irq_timer
);

  logic [15:0]  sys_cnt_q, sys_cnt_d;
  logic [7:0]   tima_q, tima_d;
  logic [7:0]   tma_q, tma_d;
  logic [2:0]   tac_q, tac_d;
  timer_state_e state_q, state_d;
  logic [1:0]   phase_q, phase_d;
  logic         irq_q, irq_d;

  logic [15:0] ofs;
  logic        wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic        tick;

  // Unsigned wrap makes addresses below the base fall out of range too.
  assign ofs          = mem_addr - BASE_ADDR;
  assign mem_selected = mem_enable & (ofs < 16'd4);

  assign wr_en   = mem_selected & mem_write & (t_cycle == 2'd3);
  assign wr_div  = wr_en & (ofs[1:0] == TIMER_OFS_DIV);
  assign wr_tima = wr_en & (ofs[1:0] == TIMER_OFS_TIMA);
  assign wr_tma  = wr_en & (ofs[1:0] == TIMER_OFS_TMA);
  assign wr_tac  = wr_en & (ofs[1:0] == TIMER_OFS_TAC);

  always_comb begin
    mem_data_out = 8'hFF;
    if (mem_selected) begin
      unique case (ofs[1:0])
        TIMER_OFS_DIV:  mem_data_out = sys_cnt_q[15:8];
        TIMER_OFS_TIMA: mem_data_out = tima_q;
        TIMER_OFS_TMA:  mem_data_out = tma_q;
        TIMER_OFS_TAC:  mem_data_out = {5'b11111, tac_q};
        default:        mem_data_out = 8'hFF;
      endcase
    end
  end

  timer_tick_detect u_tick_detect (
    .clk       (clk),
    .reset_n   (reset_n),
    .sys_cnt   (sys_cnt_q),
    .tac       (tac_q),
    .div_wr    (wr_div),
    .tac_wr    (wr_tac),
    .tac_wdata (mem_data_in[2:0]),
    .tick      (tick)
  );

  assign sys_cnt_d = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
  assign tma_d     = wr_tma ? mem_data_in : tma_q;
  assign tac_d     = wr_tac ? mem_data_in[2:0] : tac_q;

  // Overflow FSM. phase counts the four clks spent in each of OVF and RELOAD.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tima_d  = tima_q;
    irq_d   = 1'b0;
    unique case (state_q)
      TimerRun: begin
        if (wr_tima) begin
          tima_d = mem_data_in;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = TimerOvf;
            phase_d = 2'd0;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      TimerOvf: begin
        if (wr_tima) begin
          // CPU write cancels the pending reload and interrupt.
          tima_d  = mem_data_in;
          state_d = TimerRun;
        end else if (phase_q == 2'd3) begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = TimerReload;
          phase_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      TimerReload: begin
        // TIMA writes are ignored here; TMA writes pass straight through to TIMA.
        if (wr_tma) begin
          tima_d = mem_data_in;
        end
        if (phase_q == 2'd3) begin
          state_d = TimerRun;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      default: begin
        state_d = TimerRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_cnt_q <= 16'h0000;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      state_q   <= TimerRun;
      phase_q   <= 2'd0;
      irq_q     <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_timer = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer. Read expectations go through a scoreboard queue;
// interrupt pulses are logged with their cycle number and checked against expected cycles.
module tb_gb_timer;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] mem_addr = 16'h0000;
  logic        mem_enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  mem_data_in = 8'h00;
  logic [7:0]  mem_data_out;
  logic        mem_selected;
  logic        irq_timer;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int irq_q[$];

`ifdef TIMER_DIV_GLITCH_EN
  localparam bit Glitch = 1'b1;
`else
  localparam bit Glitch = 1'b0;
`endif

  gb_timer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .t_cycle      (t_cycle),
    .mem_addr     (mem_addr),
    .mem_enable   (mem_enable),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_selected (mem_selected),
    .irq_timer    (irq_timer)
  );

  always #5 clk = ~clk;

  // cyc == number of edges since reset release == free-running sys_cnt without DIV writes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (irq_timer === 1'b1) irq_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic exp_sel;
    @(negedge clk);
    mem_addr   = a;
    mem_enable = 1'b1;
    mem_write  = 1'b0;
    t_cycle    = 2'd0;
    exp_q.push_back(exp);
    exp_sel = (a >= 16'hFF04) && (a <= 16'hFF07);
    #1;
    check_eq(tag, {24'h0, mem_data_out}, {24'h0, exp_q.pop_front()});
    check_eq({tag, "_sel"}, {31'h0, mem_selected}, {31'h0, exp_sel});
    mem_enable = 1'b0;
  endtask

  task automatic rd_idle(input string tag);
    @(negedge clk);
    mem_addr   = A_TIMA;
    mem_enable = 1'b0;
    exp_q.push_back(8'hFF);
    #1;
    check_eq(tag, {24'h0, mem_data_out}, {24'h0, exp_q.pop_front()});
    check_eq({tag, "_sel"}, {31'h0, mem_selected}, 32'h0);
  endtask

  task automatic wr_t(input logic [15:0] a, input logic [7:0] d, input logic [1:0] t);
    @(negedge clk);
    mem_addr    = a;
    mem_data_in = d;
    mem_enable  = 1'b1;
    mem_write   = 1'b1;
    t_cycle     = t;
    @(posedge clk);
    #1;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    t_cycle    = 2'd0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_t(a, d, 2'd3);
  endtask

  // Returns just after edge n, before that cycle's negedge.
  task automatic at_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 100000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      n_errors++;
      $display("FAIL at_cyc: now %0d, wanted %0d", cyc, n);
    end
  endtask

  // Leaves sys_cnt == cyc - base, TAC=05 from base+1, TIMA from base+2, TMA from base+3.
  task automatic setup(input logic [7:0] t0, input logic [7:0] m0, output int base);
    wr(A_TAC, 8'h00);
    wr(A_DIV, 8'hA5);
    base = cyc;
    wr(A_TAC, 8'h05);
    wr(A_TIMA, t0);
    wr(A_TMA, m0);
  endtask

  task automatic check_irq(input string tag, input int exp_cnt, input int exp_cyc);
    check_eq({tag, "_cnt"}, irq_q.size(), exp_cnt);
    if (exp_cnt > 0 && irq_q.size() > 0) check_eq({tag, "_cyc"}, irq_q.pop_front(), exp_cyc);
    irq_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b2;

    // Reset state.
    rd(A_DIV, 8'h00, "rst_div");
    rd(A_TIMA, 8'h00, "rst_tima");
    rd(A_TMA, 8'h00, "rst_tma");
    rd(A_TAC, 8'hF8, "rst_tac");
    rd_idle("rst_idle");
    check_eq("rst_irq", {31'h0, irq_timer}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Decode and write-phase gating.
    wr_t(A_TMA, 8'h55, 2'd1);
    rd(A_TMA, 8'h00, "tcyc_gate");
    rd(16'hFF03, 8'hFF, "below_base");
    rd(16'hFF08, 8'hFF, "above_base");

    // DIV from the free-running counter.
    at_cyc(255);
    rd(A_DIV, 8'h00, "div_255");
    at_cyc(256);
    rd(A_DIV, 8'h01, "div_256");

    // Counting, overflow, reload and interrupt timing.
    setup(8'hFE, 8'h80, b);
    at_cyc(b + 4);
    rd(A_TAC, 8'hFD, "t2_tac");
    at_cyc(b + 5);
    rd(A_TMA, 8'h80, "t2_tma");
    at_cyc(b + 16);
    rd(A_TIMA, 8'hFE, "t2_pre_tick");
    at_cyc(b + 17);
    rd(A_TIMA, 8'hFF, "t2_tick");
    at_cyc(b + 32);
    rd(A_TIMA, 8'hFF, "t2_hold");
    at_cyc(b + 33);
    rd(A_TIMA, 8'h00, "t2_wrap");
    at_cyc(b + 36);
    rd(A_TIMA, 8'h00, "t2_ovf_end");
    at_cyc(b + 37);
    rd(A_TIMA, 8'h80, "t2_reload");
    at_cyc(b + 48);
    rd(A_TIMA, 8'h80, "t2_run_hold");
    at_cyc(b + 49);
    rd(A_TIMA, 8'h81, "t2_run_tick");
    check_irq("t2_irq", 1, b + 37);

    // TIMA write during OVF cancels reload and interrupt.
    setup(8'hFF, 8'h80, b);
    at_cyc(b + 18);
    rd(A_TIMA, 8'h00, "t3_ovf");
    wr(A_TIMA, 8'h42);
    at_cyc(b + 24);
    rd(A_TIMA, 8'h42, "t3_cancel");
    check_irq("t3_irq", 0, 0);

    // Writes during RELOAD.
    setup(8'hFF, 8'h80, b);
    at_cyc(b + 21);
    rd(A_TIMA, 8'h80, "t4_reload");
    wr(A_TMA, 8'h33);
    at_cyc(b + 23);
    rd(A_TIMA, 8'h33, "t4_tma_thru");
    wr(A_TIMA, 8'h99);
    at_cyc(b + 26);
    rd(A_TIMA, 8'h33, "t4_tima_ign");
    rd(A_TMA, 8'h33, "t4_tma");
    at_cyc(b + 33);
    rd(A_TIMA, 8'h34, "t4_run_tick");
    check_irq("t4_irq", 1, b + 21);

    // DIV and TAC writes while the selected tap is high.
    setup(8'h10, 8'h00, b);
    at_cyc(b + 9);
    wr(A_DIV, 8'h00);
    b2 = cyc;
    at_cyc(b2 + 2);
    rd(A_TIMA, Glitch ? 8'h11 : 8'h10, "t5_div_wr");
    at_cyc(b2 + 9);
    wr(A_TAC, 8'h04);
    at_cyc(b2 + 12);
    rd(A_TIMA, Glitch ? 8'h12 : 8'h10, "t5_tac_wr");

    // Reset in the middle of OVF.
    setup(8'hFF, 8'h80, b);
    at_cyc(b + 18);
    rd(A_TIMA, 8'h00, "t6_ovf");
    #2;
    reset_n = 1'b0;
    rd(A_TIMA, 8'h00, "t6_tima");
    rd(A_TMA, 8'h00, "t6_tma");
    rd(A_TAC, 8'hF8, "t6_tac");
    rd(A_DIV, 8'h00, "t6_div");
    rd_idle("t6_idle");
    check_eq("t6_irq_rst", {31'h0, irq_timer}, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_irq("t6_irq", 0, 0);
    rd(A_TIMA, 8'h00, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
